// File: rtl/scr1_tcm_pkg.sv
// Shared types and helpers for the TCM data-side port: command, width and
// response encodings plus lane-mask utilities.
package scr1_tcm_pkg;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    BYTE  = 2'd0,
    HWORD = 2'd1,
    WORD  = 2'd2
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OKAY  = 2'd1,
    ERROR = 2'd2
  } type_scr1_mem_resp_e;

  localparam int SCR1_TCM_NBYTES = 4;

  // Width code 3 is reserved; halfwords and words must be naturally aligned.
  function automatic logic scr1_tcm_legal(input logic [1:0] width, input logic [1:0] offset);
    logic ok;
    case (width)
      BYTE:    ok = 1'b1;
      HWORD:   ok = ~offset[0];
      WORD:    ok = (offset == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [8*SCR1_TCM_NBYTES-1:0] scr1_tcm_be2mask(input logic [SCR1_TCM_NBYTES-1:0] be);
    logic [8*SCR1_TCM_NBYTES-1:0] mask;
    for (int i = 0; i < SCR1_TCM_NBYTES; i++) begin
      mask[8*i +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/scr1_tcm_lane_align.sv
// Byte-lane alignment between right-aligned core data and the 32-bit memory
// word; LOAD_MODE selects the extract direction, otherwise the store direction.
module scr1_tcm_lane_align
  import scr1_tcm_pkg::*;
#(
  parameter bit LOAD_MODE = 1'b0
) (
  input  logic [1:0]  width_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] data_i,
  output logic [3:0]  be_o,
  output logic [31:0] data_o
);

  logic [3:0] base_be;

  always_comb begin
    case (width_i)
      BYTE:    base_be = 4'b0001;
      HWORD:   base_be = 4'b0011;
      default: base_be = 4'b1111;
    endcase
  end

  generate
    if (LOAD_MODE) begin : g_load
      // be_o stays unshifted here: it is the width mask for the right-aligned result.
      assign be_o   = base_be;
      assign data_o = data_i >> {offset_i, 3'b000};
    end else begin : g_store
      assign be_o = base_be << offset_i;
      always_comb begin
        case (width_i)
          BYTE:    data_o = {4{data_i[7:0]}};
          HWORD:   data_o = {2{data_i[15:0]}};
          default: data_o = data_i;
        endcase
      end
    end
  endgenerate

endmodule

// File: rtl/scr1_dmem_tcm_port.sv
// Data-side TCM front end: decodes core load/store requests onto memory port B
// and returns one registered response per accepted request.
module scr1_dmem_tcm_port
  import scr1_tcm_pkg::*;
#(
  parameter int unsigned SCR1_SIZE  = 32'h00010000,
  parameter int unsigned SCR1_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          dmem_req,
  input  logic                          dmem_cmd,
  input  logic [1:0]                    dmem_width,
  input  logic [$clog2(SCR1_SIZE)-1:0]  dmem_addr,
  input  logic [SCR1_WIDTH-1:0]         dmem_wdata,
  output logic                          dmem_req_ack,
  output logic [SCR1_WIDTH-1:0]         dmem_rdata,
  output logic [1:0]                    dmem_resp,
  output logic                          mem_renb,
  output logic                          mem_wenb,
  output logic [3:0]                    mem_webb,
  output logic [$clog2(SCR1_SIZE)-3:0]  mem_addrb,
  output logic [SCR1_WIDTH-1:0]         mem_datab,
  input  logic [SCR1_WIDTH-1:0]         mem_qb
);

  localparam int SCR1_AW = $clog2(SCR1_SIZE);

  logic                req_acc;
  logic                req_legal;
  logic                mem_rd;
  logic                mem_wr;
  logic [3:0]          st_be;
  logic [31:0]         st_data;
  logic [3:0]          ld_be;
  logic [31:0]         ld_data;
  type_scr1_mem_resp_e state_q, state_d;
  logic                cmd_q, cmd_d;
  logic [1:0]          width_q, width_d;
  logic [1:0]          off_q, off_d;

  assign dmem_req_ack = ~rst;
  assign req_acc      = dmem_req & ~rst;
  assign req_legal    = scr1_tcm_legal(dmem_width, dmem_addr[1:0]);
  assign mem_rd       = req_acc & req_legal & (dmem_cmd == READ);
  assign mem_wr       = req_acc & req_legal & (dmem_cmd == WRITE);

  scr1_tcm_lane_align #(.LOAD_MODE(1'b0)) u_store_align (
    .width_i  (dmem_width),
    .offset_i (dmem_addr[1:0]),
    .data_i   (dmem_wdata),
    .be_o     (st_be),
    .data_o   (st_data)
  );

  assign mem_renb  = mem_rd;
  assign mem_wenb  = mem_wr;
  assign mem_webb  = mem_wr ? st_be : 4'b0000;
  assign mem_datab = mem_wr ? st_data : '0;
  assign mem_addrb = (mem_rd | mem_wr) ? dmem_addr[SCR1_AW-1:2] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_q   <= 1'b0;
      width_q <= 2'b00;
      off_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      width_q <= width_d;
      off_q   <= off_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    cmd_d   = cmd_q;
    width_d = width_q;
    off_d   = off_q;
    if (req_acc) begin
      state_d = req_legal ? OKAY : ERROR;
      cmd_d   = dmem_cmd;
      width_d = dmem_width;
      off_d   = dmem_addr[1:0];
    end
  end

  scr1_tcm_lane_align #(.LOAD_MODE(1'b1)) u_load_align (
    .width_i  (width_q),
    .offset_i (off_q),
    .data_i   (mem_qb),
    .be_o     (ld_be),
    .data_o   (ld_data)
  );

  // mem_qb is only meaningful in the cycle after a legal read was issued.
  always_comb begin
    dmem_resp  = state_q;
    dmem_rdata = '0;
    if ((state_q == OKAY) && (cmd_q == READ)) begin
      dmem_rdata = ld_data & scr1_tcm_be2mask(ld_be);
    end
  end

endmodule
